// File: rtl/note_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_recorder : run-length {note, duration} recorder with playback to note_out
// Revision 1.0
// ---------------------------------------------------------------------------
module note_recorder #(
  parameter int DEPTH    = 64,
  parameter int NOTE_W   = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rec_pulse,
  input  logic                       play_pulse,
  input  logic [NOTE_W-1:0]          note_in,
  output logic [NOTE_W-1:0]          note_out,
  output logic                       recording,
  output logic                       playing,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] event_count
);

  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam int c_AW     = $clog2(DEPTH);
  localparam int c_EW     = NOTE_W + DUR_W;
  localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REC  = 2'd1;
  localparam logic [1:0] c_PLAY = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [NOTE_W-1:0]   r_cur_note;
  logic [DUR_W-1:0]    r_dur;
  logic [DUR_W-1:0]    r_dcnt;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_CNT_W-1:0]  r_event_count;
  logic [c_EW-1:0]     r_mem [DEPTH];

  logic                w_tick;
  logic                w_enter;
  logic [DUR_W-1:0]    w_d1;
  logic                w_seg_end;
  logic                w_dur_done;
  logic                w_last;
  logic                w_wr_req;
  logic                w_wr_en;
  logic [c_EW-1:0]     w_wr_data;
  logic [c_AW-1:0]     w_rd_ptr_nxt;
  logic [NOTE_W-1:0]   w_note_nxt;

  assign w_tick      = (r_tick_cnt == c_TICK_W'(TICK_DIV - 1));
  assign w_enter     = (w_state_nxt != r_state) && (w_state_nxt != c_IDLE);
  assign w_d1        = r_dur + DUR_W'(1);
  assign w_seg_end   = (note_in != r_cur_note) || (w_d1 == {DUR_W{1'b1}});
  assign w_dur_done  = ((r_dcnt + DUR_W'(1)) == r_mem[r_rd_ptr][DUR_W-1:0]);
  assign w_last      = (c_CNT_W'(r_rd_ptr) == (r_event_count - c_CNT_W'(1)));
  assign full        = (r_event_count == c_CNT_W'(DEPTH));
  assign event_count = r_event_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a write that finds the buffer full ends recording
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (rec_pulse)                                       w_state_nxt = c_REC;
        else if (play_pulse && (r_event_count != '0))        w_state_nxt = c_PLAY;
      end
      c_REC: begin
        if (rec_pulse)                                       w_state_nxt = c_IDLE;
        else if (w_tick && w_seg_end && full)                w_state_nxt = c_IDLE;
      end
      c_PLAY: begin
        if (play_pulse)                                      w_state_nxt = c_IDLE;
        else if (w_tick && w_dur_done && w_last)             w_state_nxt = c_IDLE;
      end
      default:                                               w_state_nxt = c_IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    w_wr_req     = 1'b0;
    w_wr_data    = {r_cur_note, w_d1};
    w_rd_ptr_nxt = r_rd_ptr;
    if (r_state == c_REC) begin
      if (rec_pulse) begin
        w_wr_req  = (r_dur != '0);
        w_wr_data = {r_cur_note, r_dur};
      end else if (w_tick && w_seg_end) begin
        w_wr_req  = 1'b1;
      end
    end
    if ((r_state == c_IDLE) && (w_state_nxt == c_PLAY))
      w_rd_ptr_nxt = '0;
    else if ((r_state == c_PLAY) && w_tick && w_dur_done)
      w_rd_ptr_nxt = r_rd_ptr + c_AW'(1);
    w_wr_en    = w_wr_req && !full;
    // Drive the upcoming entry's note so note_out tracks rd_ptr without lag
    w_note_nxt = (w_state_nxt == c_PLAY) ? r_mem[w_rd_ptr_nxt][c_EW-1:DUR_W] : note_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_out      <= '0;
      recording     <= 1'b0;
      playing       <= 1'b0;
      r_event_count <= '0;
      r_tick_cnt    <= '0;
      r_cur_note    <= '0;
      r_dur         <= '0;
      r_dcnt        <= '0;
      r_rd_ptr      <= '0;
    end else begin
      note_out  <= w_note_nxt;
      recording <= (w_state_nxt == c_REC);
      playing   <= (w_state_nxt == c_PLAY);
      r_rd_ptr  <= w_rd_ptr_nxt;

      if (w_enter || w_tick) r_tick_cnt <= '0;
      else                   r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);

      case (r_state)
        c_IDLE: begin
          if (rec_pulse) begin
            r_event_count <= '0;
            r_cur_note    <= note_in;
            r_dur         <= '0;
          end else if (play_pulse) begin
            r_dcnt <= '0;
          end
        end
        c_REC: begin
          if (!rec_pulse && w_tick) begin
            if (w_seg_end) begin
              r_cur_note <= note_in;
              r_dur      <= '0;
            end else begin
              r_dur <= w_d1;
            end
          end
          if (w_wr_en) r_event_count <= r_event_count + c_CNT_W'(1);
        end
        c_PLAY: begin
          if (w_tick) r_dcnt <= w_dur_done ? '0 : (r_dcnt + DUR_W'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_event_count[c_AW-1:0]] <= w_wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// Scoreboard bench for note_recorder: three instances cover default depth,
// a shallow buffer (DEPTH=4) and a narrow duration field (DUR_W=3).
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic       rec_a = 1'b0, play_a = 1'b0;
  logic       rec_b = 1'b0, play_b = 1'b0;
  logic       rec_c = 1'b0, play_c = 1'b0;

  logic [3:0] a_note, b_note, c_note;
  logic       a_rec, a_play, a_full, b_rec, b_play, b_full, c_rec, c_play, c_full;
  logic [6:0] a_cnt, c_cnt;
  logic [2:0] b_cnt;

  always #5 clk = ~clk;

  note_recorder #(.DEPTH(64), .NOTE_W(4), .DUR_W(8), .TICK_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .rec_pulse(rec_a), .play_pulse(play_a), .note_in(note_in),
    .note_out(a_note), .recording(a_rec), .playing(a_play), .full(a_full), .event_count(a_cnt));
  note_recorder #(.DEPTH(4), .NOTE_W(4), .DUR_W(8), .TICK_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .rec_pulse(rec_b), .play_pulse(play_b), .note_in(note_in),
    .note_out(b_note), .recording(b_rec), .playing(b_play), .full(b_full), .event_count(b_cnt));
  note_recorder #(.DEPTH(64), .NOTE_W(4), .DUR_W(3), .TICK_DIV(4)) u_c (
    .clk(clk), .rst_n(rst_n), .rec_pulse(rec_c), .play_pulse(play_c), .note_in(note_in),
    .note_out(c_note), .recording(c_rec), .playing(c_play), .full(c_full), .event_count(c_cnt));

  // Signal selectors: tens digit = instance (0=a,1=b,2=c), units = signal
  localparam int NOTE = 0, REC = 1, PLAY = 2, FULL = 3, CNT = 4;
  localparam int A = 0, B = 10, C = 20;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } chk_t;

  chk_t sbq[$];
  event chk_ev;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [15:0] get_val(input int sel);
    case (sel)
      A+NOTE: return 16'(a_note);
      A+REC:  return 16'(a_rec);
      A+PLAY: return 16'(a_play);
      A+FULL: return 16'(a_full);
      A+CNT:  return 16'(a_cnt);
      B+NOTE: return 16'(b_note);
      B+REC:  return 16'(b_rec);
      B+PLAY: return 16'(b_play);
      B+FULL: return 16'(b_full);
      B+CNT:  return 16'(b_cnt);
      C+NOTE: return 16'(c_note);
      C+REC:  return 16'(c_rec);
      C+PLAY: return 16'(c_play);
      C+FULL: return 16'(c_full);
      C+CNT:  return 16'(c_cnt);
      default: return 16'hdead;
    endcase
  endfunction

  task automatic expect_val(input string name, input int sel, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sbq.push_back(c);
  endtask

  task automatic sample();
    -> chk_ev;
    #1;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: drains the scoreboard against the live DUT outputs
  chk_t        cur;
  logic [15:0] act;
  initial begin
    forever begin
      @(chk_ev);
      while (sbq.size() > 0) begin
        cur = sbq.pop_front();
        act = get_val(cur.sel);
        checks++;
        if (act !== cur.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d at %0t", cur.name, act, cur.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_neg(2);
    rst_n = 1'b1;
    expect_val("rst_a_note", A+NOTE, 0);
    expect_val("rst_a_rec", A+REC, 0);
    expect_val("rst_a_play", A+PLAY, 0);
    expect_val("rst_a_cnt", A+CNT, 0);
    expect_val("rst_a_full", A+FULL, 0);
    sample();

    // Record 3 for 3 ticks, 5 for 2 ticks
    note_in = 4'd3; rec_a = 1'b1;
    @(negedge clk); rec_a = 1'b0;
    expect_val("rec_start", A+REC, 1);
    sample();
    wait_neg(11); note_in = 4'd5;
    expect_val("rec_cnt_before", A+CNT, 0);
    sample();
    wait_neg(1);
    expect_val("rec_cnt_first", A+CNT, 1);
    expect_val("rec_passthru", A+NOTE, 5);
    sample();
    wait_neg(8); rec_a = 1'b1;
    wait_neg(1); rec_a = 1'b0;
    expect_val("rec_cnt_final", A+CNT, 2);
    expect_val("rec_stop", A+REC, 0);
    sample();

    // Playback: 3 for 12 clk, 5 for 8 clk, then pass-through
    @(negedge clk); note_in = 4'd7; play_a = 1'b1;
    @(negedge clk); play_a = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      expect_val("play_note", A+NOTE, (k < 12) ? 16'd3 : (k < 20) ? 16'd5 : 16'd7);
      if (k == 0 || k == 19) expect_val("play_active", A+PLAY, 1);
      if (k == 20) begin
        expect_val("play_done", A+PLAY, 0);
        expect_val("play_keep_cnt", A+CNT, 2);
      end
      sample();
      if (k < 20) @(negedge clk);
    end

    // Abort mid-PLAY
    @(negedge clk); play_a = 1'b1;
    @(negedge clk); play_a = 1'b0;
    wait_neg(4); play_a = 1'b1;
    @(negedge clk); play_a = 1'b0;
    expect_val("abort_play", A+PLAY, 0);
    expect_val("abort_note", A+NOTE, 7);
    sample();

    // Corners on the empty shallow instance
    @(negedge clk); play_b = 1'b1;
    @(negedge clk); play_b = 1'b0;
    expect_val("empty_play", B+PLAY, 0);
    sample();
    @(negedge clk); rec_b = 1'b1; play_b = 1'b1;
    @(negedge clk); rec_b = 1'b0; play_b = 1'b0;
    expect_val("both_rec", B+REC, 1);
    expect_val("both_play", B+PLAY, 0);
    sample();
    rec_b = 1'b1;
    @(negedge clk); rec_b = 1'b0;
    expect_val("short_rec_cnt", B+CNT, 0);
    expect_val("short_rec_stop", B+REC, 0);
    sample();

    // Overflow: new note every tick into DEPTH=4
    @(negedge clk); note_in = 4'd1; rec_b = 1'b1;
    @(negedge clk); rec_b = 1'b0;
    wait_neg(3);  note_in = 4'd2;
    wait_neg(4);  note_in = 4'd3;
    wait_neg(4);  note_in = 4'd4;
    wait_neg(4);  note_in = 4'd5;
    wait_neg(1);
    expect_val("ovf_full", B+FULL, 1);
    expect_val("ovf_cnt4", B+CNT, 4);
    expect_val("ovf_still_rec", B+REC, 1);
    sample();
    wait_neg(3);  note_in = 4'd6;
    wait_neg(1);
    expect_val("ovf_cnt_drop", B+CNT, 4);
    expect_val("ovf_full_hold", B+FULL, 1);
    expect_val("ovf_rec_off", B+REC, 0);
    sample();

    // Saturation: note 1 for 10 ticks with DUR_W=3 -> {1,7},{1,3}
    @(negedge clk); note_in = 4'd1; rec_c = 1'b1;
    @(negedge clk); rec_c = 1'b0;
    wait_neg(27);
    expect_val("sat_cnt_pre", C+CNT, 0);
    sample();
    wait_neg(1);
    expect_val("sat_cnt_split", C+CNT, 1);
    sample();
    wait_neg(12); rec_c = 1'b1;
    wait_neg(1);  rec_c = 1'b0;
    expect_val("sat_cnt_final", C+CNT, 2);
    expect_val("sat_rec_off", C+REC, 0);
    sample();
    @(negedge clk); note_in = 4'd0; play_c = 1'b1;
    @(negedge clk); play_c = 1'b0;
    expect_val("sat_play_note", C+NOTE, 1);
    sample();
    wait_neg(39);
    expect_val("sat_play_last", C+PLAY, 1);
    expect_val("sat_note_last", C+NOTE, 1);
    sample();
    wait_neg(1);
    expect_val("sat_play_end", C+PLAY, 0);
    expect_val("sat_note_pass", C+NOTE, 0);
    sample();

    // Asynchronous reset mid-PLAY, observed before the next clock edge
    @(negedge clk); note_in = 4'd7; play_a = 1'b1;
    @(negedge clk); play_a = 1'b0;
    wait_neg(3);
    expect_val("pre_rst_play", A+PLAY, 1);
    expect_val("pre_rst_note", A+NOTE, 3);
    sample();
    #1 rst_n = 1'b0;
    #1;
    expect_val("arst_note", A+NOTE, 0);
    expect_val("arst_play", A+PLAY, 0);
    expect_val("arst_cnt", A+CNT, 0);
    sample();
    wait_neg(1); rst_n = 1'b1;
    wait_neg(1);

    #1;
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d expected 0 pending", sbq.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
